// File: rtl/simple_mac_rx_if.sv
// MII receive pins plus the payload byte stream of the receive MAC.
interface simple_mac_rx_if;
  logic       eth_rxdv;
  logic       eth_rxer;
  logic [3:0] eth_rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_sop;
  logic       rx_eop;
  logic       rx_err;

  modport master (
    input  eth_rxdv, eth_rxer, eth_rxd,
    output rx_data, rx_valid, rx_sop, rx_eop, rx_err
  );
  modport slave (
    output eth_rxdv, eth_rxer, eth_rxd,
    input  rx_data, rx_valid, rx_sop, rx_eop, rx_err
  );
endinterface

// File: rtl/simple_mac_rx.sv
// MII receive MAC: strips preamble/SFD and FCS, checks CRC-32 and length,
// and streams payload bytes with sop/eop/err framing.
module simple_mac_rx #(
  parameter int MIN_PREAMBLE = 1,
  parameter int MIN_FRAME    = 64,
  parameter int MAX_FRAME    = 1518
) (
  input  logic                   eth_rxclk,
  input  logic                   rst,
  simple_mac_rx_if.master        bus,
  output logic [15:0]            rx_good_frames,
  output logic [15:0]            rx_bad_frames
);
  localparam int CW = $clog2(MAX_FRAME + 2);
  localparam int PW = $clog2(MIN_PREAMBLE + 2);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {S_DROP, S_IDLE, S_PRE, S_DATA} state_t;

  state_t            state;
  logic [PW-1:0]     pre_cnt;
  logic [CW-1:0]     byte_cnt;
  logic [CW-1:0]     k_next;
  logic              phase;
  logic [3:0]        nib_lo;
  logic [31:0]       crc;
  logic              err_seen;
  logic [4:0][7:0]   sbuf;      // [4] is the oldest byte
  logic [7:0]        cur_byte;
  logic              bad_end;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign cur_byte = {bus.eth_rxd, nib_lo};
  assign k_next   = (byte_cnt == CW'(MAX_FRAME + 1)) ? byte_cnt : byte_cnt + 1'b1;
  assign bad_end  = (crc != CRC_RESIDUE) || (byte_cnt < CW'(MIN_FRAME)) || phase || err_seen;

  always_ff @(posedge eth_rxclk) begin
    if (rst) begin
      state          <= S_DROP;
      pre_cnt        <= '0;
      byte_cnt       <= '0;
      phase          <= 1'b0;
      nib_lo         <= '0;
      crc            <= '1;
      err_seen       <= 1'b0;
      sbuf           <= '0;
      bus.rx_data    <= '0;
      bus.rx_valid   <= 1'b0;
      bus.rx_sop     <= 1'b0;
      bus.rx_eop     <= 1'b0;
      bus.rx_err     <= 1'b0;
      rx_good_frames <= '0;
      rx_bad_frames  <= '0;
    end else begin
      bus.rx_valid <= 1'b0;
      bus.rx_sop   <= 1'b0;
      bus.rx_eop   <= 1'b0;
      bus.rx_err   <= 1'b0;
      case (state)
        S_DROP: if (!bus.eth_rxdv) state <= S_IDLE;
        S_IDLE: if (bus.eth_rxdv) begin
          if (bus.eth_rxd == 4'h5) begin
            state   <= S_PRE;
            pre_cnt <= PW'(1);
          end else begin
            state         <= S_DROP;
            rx_bad_frames <= rx_bad_frames + 16'd1;
          end
        end
        S_PRE: begin
          if (!bus.eth_rxdv) begin
            state         <= S_IDLE;
            rx_bad_frames <= rx_bad_frames + 16'd1;
          end else if (!bus.eth_rxer && bus.eth_rxd == 4'h5) begin
            if (pre_cnt < PW'(MIN_PREAMBLE)) pre_cnt <= pre_cnt + 1'b1;
          end else if (!bus.eth_rxer && bus.eth_rxd == 4'hD && pre_cnt >= PW'(MIN_PREAMBLE)) begin
            state    <= S_DATA;
            byte_cnt <= '0;
            crc      <= '1;
            phase    <= 1'b0;
            err_seen <= 1'b0;
          end else begin
            state         <= S_DROP;
            rx_bad_frames <= rx_bad_frames + 16'd1;
          end
        end
        S_DATA: begin
          if (bus.eth_rxdv) begin
            if (bus.eth_rxer) err_seen <= 1'b1;
            phase <= ~phase;
            if (!phase) begin
              nib_lo <= bus.eth_rxd;
            end else begin
              crc      <= crc_upd(crc, cur_byte);
              byte_cnt <= k_next;
              sbuf     <= {sbuf[3:0], cur_byte};
              // The 5-deep delay hides the 4 FCS bytes; the oldest byte leaves once it is known to be payload.
              if (k_next >= CW'(6)) begin
                bus.rx_data  <= sbuf[4];
                bus.rx_valid <= 1'b1;
                bus.rx_sop   <= (k_next == CW'(6));
              end
              if (k_next == CW'(MAX_FRAME + 1)) begin
                bus.rx_eop    <= 1'b1;
                bus.rx_err    <= 1'b1;
                rx_bad_frames <= rx_bad_frames + 16'd1;
                state         <= S_DROP;
              end
            end
          end else begin
            state <= S_IDLE;
            if (byte_cnt >= CW'(5)) begin
              bus.rx_data  <= sbuf[4];
              bus.rx_valid <= 1'b1;
              bus.rx_eop   <= 1'b1;
              bus.rx_sop   <= (byte_cnt == CW'(5));
              bus.rx_err   <= bad_end;
              if (bad_end) rx_bad_frames  <= rx_bad_frames + 16'd1;
              else         rx_good_frames <= rx_good_frames + 16'd1;
            end else begin
              rx_bad_frames <= rx_bad_frames + 16'd1;
            end
          end
        end
        default: state <= S_DROP;
      endcase
    end
  end
endmodule

// File: tb/tb_simple_mac_rx.sv
// Directed bench for simple_mac_rx: builds frames with a software FCS and
// checks framing, payload, error flags and frame counters.
module tb_simple_mac_rx;
  logic        eth_rxclk = 1'b0;
  logic        rst;
  logic [15:0] good, bad;

  simple_mac_rx_if mac_if ();

  simple_mac_rx #(.MIN_PREAMBLE(1), .MIN_FRAME(64), .MAX_FRAME(1518)) dut (
    .eth_rxclk      (eth_rxclk),
    .rst            (rst),
    .bus            (mac_if),
    .rx_good_frames (good),
    .rx_bad_frames  (bad)
  );

  always #5 eth_rxclk = ~eth_rxclk;

  int n_assert = 0;
  int n_fail   = 0;

  // Output monitor, sampled on the falling edge
  logic [7:0] rxbuf [0:4095];
  logic [7:0] frm   [0:1699];
  int   n_valid = 0, n_sop = 0, n_eop = 0, sop_idx = -1, eop_idx = -1, n_stray = 0;
  logic eop_err = 1'b0;

  always @(negedge eth_rxclk) begin
    if (mac_if.rx_err === 1'b1 && !(mac_if.rx_valid === 1'b1 && mac_if.rx_eop === 1'b1))
      n_stray = n_stray + 1;
    if (mac_if.rx_valid === 1'b1) begin
      if (n_valid < 4096) rxbuf[n_valid] = mac_if.rx_data;
      if (mac_if.rx_sop === 1'b1) begin n_sop = n_sop + 1; sop_idx = n_valid; end
      if (mac_if.rx_eop === 1'b1) begin n_eop = n_eop + 1; eop_idx = n_valid; eop_err = mac_if.rx_err; end
      n_valid = n_valid + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build(input int len);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++) frm[i] = 8'($urandom);
    if (len >= 4) begin
      for (int i = 0; i < len - 4; i++) c = crc_byte(c, frm[i]);
      c = ~c;
      for (int j = 0; j < 4; j++) frm[len - 4 + j] = c[8*j +: 8];
    end
  endtask

  task automatic nib(input logic dv, input logic er, input logic [3:0] d);
    mac_if.eth_rxdv = dv;
    mac_if.eth_rxer = er;
    mac_if.eth_rxd  = d;
    @(posedge eth_rxclk);
    #1;
  endtask

  // stop_at >= 0 leaves the frame hanging after that many bytes
  task automatic send_frame(input int npre, input int len, input int er_byte,
                            input bit extra_nib, input int stop_at);
    for (int i = 0; i < npre; i++) nib(1'b1, 1'b0, 4'h5);
    nib(1'b1, 1'b0, 4'hD);
    for (int i = 0; i < len; i++) begin
      if (i == stop_at) return;
      nib(1'b1, (i == er_byte), frm[i][3:0]);
      nib(1'b1, 1'b0, frm[i][7:4]);
    end
    if (extra_nib) nib(1'b1, 1'b0, 4'h0);
    repeat (12) nib(1'b0, 1'b0, 4'h0);
  endtask

  task automatic check_frame(input string tag, input int v0, input int s0, input int e0,
                             input int exp_n, input logic exp_err);
    int mism;
    mism = 0;
    chk({tag, ".nvalid"}, n_valid - v0, exp_n);
    chk({tag, ".nsop"},   n_sop - s0, 1);
    chk({tag, ".sop_pos"}, sop_idx, v0);
    chk({tag, ".neop"},   n_eop - e0, 1);
    chk({tag, ".eop_pos"}, eop_idx, v0 + exp_n - 1);
    chk({tag, ".eop_err"}, {31'h0, eop_err}, {31'h0, exp_err});
    for (int i = 0; i < exp_n; i++) if (rxbuf[v0 + i] !== frm[i]) mism++;
    chk({tag, ".payload"}, mism, 0);
  endtask

  initial begin
    int v0, s0, e0;
    rst = 1'b1;
    mac_if.eth_rxdv = 1'b0;
    mac_if.eth_rxer = 1'b0;
    mac_if.eth_rxd  = 4'h0;
    repeat (3) @(posedge eth_rxclk);
    #1;
    chk("rst.valid", {31'h0, mac_if.rx_valid}, 0);
    chk("rst.sop",   {31'h0, mac_if.rx_sop}, 0);
    chk("rst.eop",   {31'h0, mac_if.rx_eop}, 0);
    chk("rst.err",   {31'h0, mac_if.rx_err}, 0);
    chk("rst.data",  {24'h0, mac_if.rx_data}, 0);
    chk("rst.good",  {16'h0, good}, 0);
    chk("rst.bad",   {16'h0, bad}, 0);
    rst = 1'b0;
    repeat (2) nib(1'b0, 1'b0, 4'h0);

    // good 64B frame
    build(64);
    v0 = n_valid; s0 = n_sop; e0 = n_eop;
    send_frame(7, 64, -1, 1'b0, -1);
    check_frame("good64", v0, s0, e0, 60, 1'b0);
    chk("good64.good", {16'h0, good}, 1);
    chk("good64.bad",  {16'h0, bad}, 0);

    // same frame, one FCS bit flipped
    frm[63] = frm[63] ^ 8'h01;
    v0 = n_valid; s0 = n_sop; e0 = n_eop;
    send_frame(7, 64, -1, 1'b0, -1);
    check_frame("badfcs", v0, s0, e0, 60, 1'b1);
    chk("badfcs.good", {16'h0, good}, 1);
    chk("badfcs.bad",  {16'h0, bad}, 1);

    // rxer pulse at byte 20 of a valid 100B frame
    build(100);
    v0 = n_valid; s0 = n_sop; e0 = n_eop;
    send_frame(7, 100, 19, 1'b0, -1);
    check_frame("rxer", v0, s0, e0, 96, 1'b1);
    chk("rxer.bad", {16'h0, bad}, 2);

    // 3-byte runt
    build(3);
    v0 = n_valid; e0 = n_eop;
    send_frame(7, 3, -1, 1'b0, -1);
    chk("runt.nvalid", n_valid - v0, 0);
    chk("runt.neop",   n_eop - e0, 0);
    chk("runt.bad",    {16'h0, bad}, 3);

    // preamble fault 5,5,7 then junk with rxdv held high
    v0 = n_valid;
    nib(1'b1, 1'b0, 4'h5); nib(1'b1, 1'b0, 4'h5); nib(1'b1, 1'b0, 4'h7);
    chk("prefault.bad_early", {16'h0, bad}, 4);
    for (int i = 0; i < 10; i++) nib(1'b1, 1'b0, (i == 5) ? 4'hD : 4'h5);
    repeat (12) nib(1'b0, 1'b0, 4'h0);
    chk("prefault.nvalid", n_valid - v0, 0);
    chk("prefault.bad",    {16'h0, bad}, 4);

    // next good frame, minimal preamble
    build(64);
    v0 = n_valid; s0 = n_sop; e0 = n_eop;
    send_frame(1, 64, -1, 1'b0, -1);
    check_frame("recover", v0, s0, e0, 60, 1'b0);
    chk("recover.good", {16'h0, good}, 2);

    // 1600B oversize frame
    build(1600);
    v0 = n_valid; s0 = n_sop; e0 = n_eop;
    send_frame(7, 1600, -1, 1'b0, -1);
    check_frame("oversize", v0, s0, e0, 1514, 1'b1);
    chk("oversize.bad",  {16'h0, bad}, 5);
    chk("oversize.good", {16'h0, good}, 2);

    // reset mid-frame
    build(64);
    e0 = n_eop;
    send_frame(7, 64, -1, 1'b0, 30);
    rst = 1'b1;
    nib(1'b1, 1'b0, frm[30][3:0]);
    rst = 1'b0;
    chk("midrst.valid", {31'h0, mac_if.rx_valid}, 0);
    chk("midrst.eop",   {31'h0, mac_if.rx_eop}, 0);
    chk("midrst.good",  {16'h0, good}, 0);
    chk("midrst.bad",   {16'h0, bad}, 0);
    v0 = n_valid;
    for (int i = 31; i < 64; i++) begin
      nib(1'b1, 1'b0, frm[i][3:0]);
      nib(1'b1, 1'b0, frm[i][7:4]);
    end
    repeat (12) nib(1'b0, 1'b0, 4'h0);
    chk("midrst.nvalid_after", n_valid - v0, 0);
    chk("midrst.neop", n_eop - e0, 0);
    chk("midrst.bad_after", {16'h0, bad}, 0);
    build(64);
    v0 = n_valid; s0 = n_sop; e0 = n_eop;
    send_frame(7, 64, -1, 1'b0, -1);
    check_frame("postrst", v0, s0, e0, 60, 1'b0);
    chk("postrst.good", {16'h0, good}, 1);

    // odd nibble count on a 64B frame
    build(64);
    v0 = n_valid; s0 = n_sop; e0 = n_eop;
    send_frame(7, 64, -1, 1'b1, -1);
    check_frame("oddnib", v0, s0, e0, 60, 1'b1);
    chk("oddnib.bad",  {16'h0, bad}, 1);
    chk("oddnib.good", {16'h0, good}, 1);

    chk("err_without_eop", n_stray, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
